spi_boot_loader: RTL

- Receives the ARM's SPI boot download and writes the payload into the external 256K×8 SRAM before the BBC core is released.
- Stream format is little-endian throughout:
  - bytes 0-2: 24-bit start address;
  - bytes 3-5: 24-bit end address (inclusive);
  - then one data byte per address.
- Sits between the top-level arm_ss/arm_sclk/arm_mosi pins and the SRAM port mux. While booting is high, the mux gives this block ownership of ADR/DAT/RAMWE_b/RAMCS_b and holds the core in reset.

---
 rtl/spi_boot_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_boot_loader.sv
// SPI boot download receiver: takes a little-endian start/end header from the ARM
// and writes each following data byte into the external SRAM before the core is released.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | ss high, aborted, or download finished (booting=0)
// S_HDR     | collecting the 6 header bytes (start, end)
// S_DATA    | waiting for a data byte to write at cur_addr
// S_W_SETUP | address/data/cs_b driven, we_b still high
// S_W_LOW   | we_b low for WE_LOW_CYCLES clocks
// S_W_HOLD  | we_b back high, cs_b still low; then cur_addr advances
module spi_boot_loader #(
  parameter int SYNC_STAGES   = 2,
  parameter int WE_LOW_CYCLES = 2,
  parameter int ADDR_BITS     = 18
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 spi_ss,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 booting,
  output logic [ADDR_BITS-1:0] ram_a,
  output logic [7:0]           ram_d,
  output logic                 ram_cs_b,
  output logic                 ram_we_b,
  output logic                 overrun
);

  localparam int WE_CW = $clog2(WE_LOW_CYCLES + 1);
  localparam logic [WE_CW-1:0] WE_LOAD = WE_CW'(WE_LOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_W_SETUP, S_W_LOW, S_W_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic ss_prev_q, ss_prev_d, sclk_prev_q, sclk_prev_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] byte_cnt_q, byte_cnt_d;
  logic byte_valid_q, byte_valid_d;
  logic [7:0] byte_q, byte_d;
  logic [23:0] start_q, start_d, end_q, end_d, cur_addr_q, cur_addr_d;
  logic [WE_CW-1:0] we_cnt_q, we_cnt_d;
  logic pend_q, pend_d, pend_abort_q, pend_abort_d;
  logic booting_q, booting_d;
  logic [ADDR_BITS-1:0] ram_a_q, ram_a_d;
  logic [7:0] ram_d_q, ram_d_d;
  logic ram_cs_b_q, ram_cs_b_d, ram_we_b_q, ram_we_b_d;
  logic overrun_q, overrun_d;

  logic ss_s, sclk_s, mosi_s, ss_rise, ss_fall, sclk_rise, partial, in_write;
  logic       byte_valid;
  logic [7:0] byte_data;

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign partial   = (bit_cnt_q != 3'd0);
  assign in_write  = (state_q == S_W_SETUP) || (state_q == S_W_LOW) || (state_q == S_W_HOLD);
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;

  always_comb begin
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ss_prev_d    = ss_s;
    sclk_prev_d  = sclk_s;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    start_d      = start_q;
    end_d        = end_q;
    cur_addr_d   = cur_addr_q;
    we_cnt_d     = we_cnt_q;
    pend_d       = pend_q;
    pend_abort_d = pend_abort_q;
    booting_d    = booting_q;
    ram_a_d      = ram_a_q;
    ram_d_d      = ram_d_q;
    overrun_d    = overrun_q;
    state_d      = state_q;

    if (sclk_rise && !ss_s && booting_q && state_q != S_IDLE) begin
      sr_d      = {sr_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = {sr_q, mosi_s};
      end
    end
    if (byte_valid && byte_cnt_q != 3'd6) byte_cnt_d = byte_cnt_q + 3'd1;
    if (ss_rise) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 3'd0;
    end

    case (state_q)
      S_IDLE: if (ss_fall && booting_q) state_d = S_HDR;
      S_HDR: begin
        if (ss_rise) state_d = S_IDLE;
        else if (byte_valid) begin
          case (byte_cnt_q)
            3'd0: start_d[7:0]   = byte_data;
            3'd1: start_d[15:8]  = byte_data;
            3'd2: start_d[23:16] = byte_data;
            3'd3: end_d[7:0]     = byte_data;
            3'd4: end_d[15:8]    = byte_data;
            3'd5: begin
              end_d[23:16] = byte_data;
              cur_addr_d   = start_q;
              state_d      = S_DATA;
            end
            default: ;
          endcase
        end
      end
      S_DATA: begin
        if (ss_rise) begin
          state_d = S_IDLE;
          if (!partial) booting_d = 1'b0;
        end else if (byte_valid && cur_addr_q <= end_q) begin
          state_d = S_W_SETUP;
          ram_a_d = cur_addr_q[ADDR_BITS-1:0];
          ram_d_d = byte_data;
        end
      end
      S_W_SETUP: begin
        state_d  = S_W_LOW;
        we_cnt_d = WE_LOAD;
      end
      S_W_LOW: begin
        if (we_cnt_q == '0) state_d = S_W_HOLD;
        else we_cnt_d = we_cnt_q - WE_CW'(1);
      end
      S_W_HOLD: begin
        cur_addr_d   = cur_addr_q + 24'd1;
        pend_d       = 1'b0;
        pend_abort_d = 1'b0;
        if (pend_q || ss_rise) begin
          state_d = S_IDLE;
          if (!(pend_abort_q || (ss_rise && partial))) booting_d = 1'b0;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_write && byte_valid) overrun_d = 1'b1;
    // ss rising mid-write is remembered and acted on once the write finishes
    if (in_write && ss_rise && state_q != S_W_HOLD) begin
      pend_d       = 1'b1;
      pend_abort_d = partial;
    end

    ram_cs_b_d = !((state_d == S_W_SETUP) || (state_d == S_W_LOW) || (state_d == S_W_HOLD));
    ram_we_b_d = (state_d != S_W_LOW);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      ss_sync_q    <= '0;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ss_prev_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      start_q      <= '0;
      end_q        <= '0;
      cur_addr_q   <= '0;
      we_cnt_q     <= '0;
      pend_q       <= 1'b0;
      pend_abort_q <= 1'b0;
      booting_q    <= 1'b1;
      ram_a_q      <= '0;
      ram_d_q      <= '0;
      ram_cs_b_q   <= 1'b1;
      ram_we_b_q   <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_sync_q    <= ss_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_prev_q    <= ss_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      start_q      <= start_d;
      end_q        <= end_d;
      cur_addr_q   <= cur_addr_d;
      we_cnt_q     <= we_cnt_d;
      pend_q       <= pend_d;
      pend_abort_q <= pend_abort_d;
      booting_q    <= booting_d;
      ram_a_q      <= ram_a_d;
      ram_d_q      <= ram_d_d;
      ram_cs_b_q   <= ram_cs_b_d;
      ram_we_b_q   <= ram_we_b_d;
      overrun_q    <= overrun_d;
    end
  end

  assign booting  = booting_q;
  assign ram_a    = ram_a_q;
  assign ram_d    = ram_d_q;
  assign ram_cs_b = ram_cs_b_q;
  assign ram_we_b = ram_we_b_q;
  assign overrun  = overrun_q;

endmodule
